// File: rtl/sign_mag_add_pipe.sv
// Two-stage pipelined sign-magnitude adder/accumulator with valid/ready streams.
// Stage 1 holds the accepted beat; stage 2 is the output register.
module sign_mag_add_pipe #(
   parameter int unsigned N     = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   input  logic             mode,
   input  logic             sat_en,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     sum,
   output logic             ovf,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] ovf_count
);
   localparam int unsigned M = N - 1;

   // Stage 1 beat
   logic         s1_valid_q, s1_valid_d;
   logic [N-1:0] s1_a_q, s1_a_d;
   logic [N-1:0] s1_b_q, s1_b_d;
   logic         s1_mode_q, s1_mode_d;
   logic         s1_sat_q, s1_sat_d;

   // Stage 2 / status
   logic             out_valid_q, out_valid_d;
   logic [N-1:0]     sum_q, sum_d;
   logic             ovf_q, ovf_d;
   logic [N-1:0]     acc_q, acc_d;
   logic             ovf_sticky_q, ovf_sticky_d;
   logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

   logic s2_adv, s1_adv, in_fire;

   // Datapath
   logic [N-1:0] acc_eff, op_x, op_y;
   logic [M-1:0] mag_x, mag_y, res_mag;
   logic         sgn_x, sgn_y, res_sgn, res_ovf;
   logic [M:0]   mag_sum;
   logic [N-1:0] result;

   always_comb begin
      s2_adv   = !out_valid_q | out_ready;
      s1_adv   = s1_valid_q & s2_adv;
      in_ready = !s1_valid_q | s2_adv;
      in_fire  = in_valid & in_ready;
   end

   // A clear in the same cycle as an accumulate advance makes that beat start from zero.
   always_comb begin
      acc_eff = clear ? '0 : acc_q;
      op_x    = s1_mode_q ? acc_eff : s1_a_q;
      op_y    = s1_mode_q ? s1_a_q  : s1_b_q;
      mag_x   = op_x[M-1:0];
      mag_y   = op_y[M-1:0];
      // -0 is folded to +0 before the sign comparison
      sgn_x   = op_x[N-1] & (|mag_x);
      sgn_y   = op_y[N-1] & (|mag_y);
      mag_sum = {1'b0, mag_x} + {1'b0, mag_y};
      res_ovf = 1'b0;
      res_mag = '0;
      res_sgn = 1'b0;
      if (sgn_x == sgn_y) begin
         res_ovf = mag_sum[M];
         res_mag = (res_ovf && s1_sat_q) ? '1 : mag_sum[M-1:0];
         res_sgn = sgn_x;
      end else if (mag_x >= mag_y) begin
         res_mag = mag_x - mag_y;
         res_sgn = sgn_x;
      end else begin
         res_mag = mag_y - mag_x;
         res_sgn = sgn_y;
      end
      result = {res_sgn & (|res_mag), res_mag};
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_mode_d  = s1_mode_q;
      s1_sat_d   = s1_sat_q;
      if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_a_d     = a;
         s1_b_d     = b;
         s1_mode_d  = mode;
         s1_sat_d   = sat_en;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      ovf_d       = ovf_q;
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
      end
      if (s1_adv) begin
         sum_d = result;
         ovf_d = res_ovf;
      end
   end

   always_comb begin
      acc_d        = clear ? '0 : acc_q;
      ovf_sticky_d = clear ? 1'b0 : ovf_sticky_q;
      ovf_count_d  = clear ? '0 : ovf_count_q;
      if (s1_adv && s1_mode_q) begin
         acc_d = result;
      end
      if (s1_adv && res_ovf) begin
         ovf_sticky_d = 1'b1;
         if (ovf_count_d != '1) begin
            ovf_count_d = ovf_count_d + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s1_mode_q    <= 1'b0;
         s1_sat_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         sum_q        <= '0;
         ovf_q        <= 1'b0;
         acc_q        <= '0;
         ovf_sticky_q <= 1'b0;
         ovf_count_q  <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         s1_mode_q    <= s1_mode_d;
         s1_sat_q     <= s1_sat_d;
         out_valid_q  <= out_valid_d;
         sum_q        <= sum_d;
         ovf_q        <= ovf_d;
         acc_q        <= acc_d;
         ovf_sticky_q <= ovf_sticky_d;
         ovf_count_q  <= ovf_count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign sum        = sum_q;
   assign ovf        = ovf_q;
   assign ovf_sticky = ovf_sticky_q;
   assign ovf_count  = ovf_count_q;

endmodule

// File: doc/sign_mag_add_pipe.md
Name: sign_mag_add_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational 4-bit sign-magnitude adder.
- Adds two N-bit sign-magnitude operands, or accumulates one operand into an internal running total.
- Provides a valid/ready stream on both sides, selectable wrap or saturate overflow handling, and overflow status with a saturating counter.
- Sits between an operand source (e.g. ROM or stimulus stream) and a downstream consumer.

Parameters:
N, 4, total operand/result width; bit N-1 is the sign, bits N-2:0 are the magnitude (N >= 2)
CNT_W, 8, width of the overflow event counter

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous reset, active-low
in_valid  input  1  operand beat offered
in_ready  output  1  block accepts a beat this cycle
a  input  N  operand A, sign-magnitude
b  input  N  operand B, sign-magnitude; ignored when mode=1
mode  input  1  0 = sum a+b; 1 = acc <= acc+a
sat_en  input  1  1 = saturate on overflow, 0 = wrap; sampled with the beat
clear  input  1  synchronous clear of acc, ovf_sticky, ovf_count
out_valid  output  1  result available
out_ready  input  1  consumer takes result this cycle
sum  output  N  result, sign-magnitude, never -0
ovf  output  1  overflow flag for the current result
ovf_sticky  output  1  set by any overflow; cleared by clear
ovf_count  output  CNT_W  number of overflowed results, saturating at all-ones

Behaviour:
- Clock and reset:
  - One clock domain.
  - rst_n low asynchronously zeroes every register: S1 valid/operands, out_valid=0, sum=0, ovf=0, acc=0, ovf_sticky=0, ovf_count=0.
  - After reset, in_ready=1.
  - Reset mid-operation discards all in-flight beats.
- Pipeline:
  - Two stages. S1 registers a, b, mode, sat_en. S2 is the output register (sum, ovf, out_valid).
  - Beat accepted on in_valid & in_ready.
  - Latency is 2 cycles: accept at edge k, out_valid at edge k+2 when unstalled.
  - Throughput is 1 beat/cycle.
- Flow control:
  - s2_adv = !out_valid | out_ready.
  - S1 advances into S2 when s1_valid & s2_adv.
  - in_ready = !s1_valid | s2_adv (combinational, no skid buffer).
  - A result transfers on out_valid & out_ready.
  - While out_valid=1 & out_ready=0, sum and ovf are held stable; at most 2 beats are buffered.
- Operand selection (computed combinationally from S1 when S1 advances):
  - X = (mode ? acc : a), Y = a for mode=1; X = a, Y = b for mode=0.
  - Magnitudes are M = N-1 bits. An input of -0 is treated as +0.
- Same signs:
  - mag = |X| + |Y| in M+1 bits; ovf = carry out.
  - Wrap: result magnitude = low M bits.
  - Sat: result magnitude = all ones.
  - Result sign = common sign.
- Different signs:
  - Result magnitude = larger |.| minus smaller |.|; sign = sign of the larger.
  - Equal magnitudes give +0. ovf=0.
- Canonical zero: any zero result magnitude (including wrap overflow) is emitted with sign 0.
- Accumulator:
  - When an S1 beat with mode=1 advances, acc <= result (same value as sum).
  - mode=0 beats never touch acc.
- Clear:
  - While clear=1, acc, ovf_sticky and ovf_count are zeroed.
  - If clear coincides with a mode=1 advance, X uses acc=0. acc <= 0+a result; ovf_sticky and ovf_count take that beat's ovf.
  - Clear does not flush the pipeline or alter sum/ovf already in S2.
- Overflow status:
  - On each advance with ovf=1, ovf_sticky <= 1.
  - ovf_count increments by 1, holding at 2^CNT_W-1.
- sat_en and mode travel with the beat; changing them between beats has no effect on beats already in flight.

Test Plan:
- N=4, mode=0, sat_en=0: a=0011, b=0010 -> sum=0101, ovf=0; a=0011, b=1101 -> sum=1010; a=0101, b=1011 -> sum=0010; results appear 2 cycles after accept, one per cycle back-to-back.
- Zero cases: a=0011, b=1011 -> sum=0000; a=1000, b=0000 -> sum=0000; a=1000, b=1000 -> sum=0000, ovf=0.
- Overflow: a=0100, b=0100 with sat_en=0 -> sum=0000, ovf=1; same with sat_en=1 -> 0111, ovf=1; a=1110, b=1110 with sat_en=1 -> 1111; ovf_sticky=1, ovf_count=3.
- Accumulate: clear, then mode=1, a=0011 three times -> sums 0011, 0110, 0001 (ovf=1, wrap); repeat with sat_en=1 on the third beat -> 0111; then a=1010 -> 0101 (from acc=0111).
- Backpressure: out_ready=0, offer 4 beats -> 2 accepted, in_ready=0 next cycle; sum held stable; raise out_ready -> results drain in order with no loss or duplication.
- Async reset with pipeline full and acc=0110: rst_n low mid-cycle -> out_valid=0, sum=0, acc=0, ovf_count=0 immediately, in_ready=1 after release; clear asserted on the same cycle as a mode=1 beat a=0010 -> acc=0010.
